i2s_rx_frame_buffer: RTL and testbench
======================================

// Module: i2s_rx_frame_buffer
// PURPOSE
//  Parametrised I2S receiver with a sample FIFO and a speech-activity flag.
//  Oversamples serial I2S (sck/ws/sd) in the clk domain and deserialises per-channel samples.
//  Buffers samples in a FIFO and presents them on a valid/ready stream to the feature-extraction pipeline.
//  Replaces the single-register capture stage at the head of the audio pipeline.
// PARAMETERS
//  DATA_W     16    sample width in bits; MSB-first; extra slot bits are ignored
//  NUM_CH     2     1 = left only (ws=0); 2 = left+right
//  FIFO_DEPTH 16    FIFO entries; power of 2, >=2
//  VAD_THRESH 512   |sample| >= this marks activity (unsigned, DATA_W bits)
//  VAD_HANG   256   accepted samples speech_valid stays high after the last active sample
// PORTS
//  clk          in   1                 system clock; must be >= 4x i2s_sck
//  rst_n        in   1                 reset, asynchronous, active-low
//  en           in   1                 receiver enable
//  i2s_sck      in   1                 I2S bit clock (async)
//  i2s_ws       in   1                 I2S word select (async); 0 = left/ch0, 1 = right/ch1
//  i2s_sd       in   1                 I2S serial data (async)
//  out_data     out  DATA_W            sample, two's complement
//  out_ch       out  1                 channel of out_data (0 = left)
//  out_valid    out  1                 out_data/out_ch valid
//  out_ready    in   1                 consumer accepts when out_valid && out_ready
//  fifo_level   out  $clog2(DEPTH)+1   entries currently held
//  overflow     out  1                 sticky; set on a sample dropped while full
//  ovf_clr      in   1                 synchronous clear of overflow (set wins if same cycle)
//  frame_err    out  1                 1-cycle pulse when a slot is shorter than DATA_W bits
//  speech_valid out  1                 activity flag
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; deserialiser IDLE; VAD counter 0.
//  Sync: 2-FF synchroniser on sck/ws/sd. Bit event = synchronised sck rising edge (0->1).
//  FSM: IDLE -> WAIT_WS -> SHIFT.
//   - IDLE: entered on reset or en=0. en=1 -> WAIT_WS.
//   - WAIT_WS: wait for a ws transition seen on a bit event -> SHIFT; channel = new ws value.
//   - SHIFT: the first bit event after the ws edge is skipped (I2S one-bit delay).
//     Subsequent bits shift in MSB-first. After DATA_W bits, push {ch, sample}; ignore the rest of the slot.
//   - A ws edge before DATA_W bits are captured: discard the partial sample, pulse frame_err, restart SHIFT for the new channel.
//   - NUM_CH=1: ws=1 slots are never pushed (no frame_err).
//   - en=0: go to IDLE at once and discard any partial sample. FIFO still drains.
//  FIFO:
//   - First-word-fall-through. A push into an empty FIFO asserts out_valid on the next cycle.
//   - out_data/out_ch hold stable while out_valid && !out_ready.
//   - Push when full: sample dropped and overflow set; if a pop happens in the same cycle, the push is accepted.
//   - Pop and push in the same cycle: fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
//  VAD (applies only to pushed samples):
//   - abs = |sample|; the most negative value saturates to 2^(DATA_W-1)-1.
//   - abs >= VAD_THRESH: counter <= VAD_HANG.
//   - Otherwise, if counter > 0: counter decrements by 1.
//   - speech_valid = (counter != 0), registered; updates the cycle after the push.
//  Latency: final data bit's sck edge on the pins -> out_valid = 2 sync + 1 shift + 1 push = 4 clk max (FIFO empty).
// CONFIGURATION
//  I2S_RX_VAD_EN defined: VAD logic as described above.
//  I2S_RX_VAD_EN undefined: no VAD logic; speech_valid = out_valid; VAD_THRESH and VAD_HANG are unused.
// TESTING
//  1. DATA_W=16, NUM_CH=2, left=16'h1234, right=16'hFEDC, out_ready=1.
//     Expect: out (0,1234) then (1,FEDC); each out_valid <= 4 clk after the last bit.
//  2. 32-bit slots carrying 16-bit samples.
//     Expect: upper 16 bits captured, low 16 ignored, no frame_err.
//  3. out_ready=0, push FIFO_DEPTH+2 samples.
//     Expect: fifo_level=16, overflow=1, first 16 samples read back in order.
//     Then ovf_clr=1 -> overflow=0.
//  4. ws toggles after 8 bits.
//     Expect: frame_err pulses once, nothing pushed; next full slot pushed normally.
//  5. VAD (I2S_RX_VAD_EN, VAD_HANG=4): one sample 16'h8000, then zeros.
//     Expect: speech_valid=1 after the 16'h8000 push and low after the 4th zero push.
//  6. en=0 mid-slot, then rst_n=0 with 3 entries queued.
//     Expect: partial sample discarded; after reset all outputs 0 and fifo_level=0.

Source files
------------

// File: rtl/i2s_rx_frame_buffer.sv
// I2S receiver: oversampled deserialiser, first-word-fall-through sample FIFO and speech-activity flag.
// Define I2S_RX_VAD_EN to build the activity detector; otherwise speech_valid mirrors out_valid.
module i2s_rx_frame_buffer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned VAD_THRESH = 512,
    parameter int unsigned VAD_HANG   = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          i2s_sck,
    input  logic                          i2s_ws,
    input  logic                          i2s_sd,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          frame_err,
    output logic                          speech_valid
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StWaitWs, StShift} state_e;

    // Synchronisers; the third sck stage gives the rising-edge detect
    logic [2:0] sck_q;
    logic [1:0] ws_q, sd_q;
    logic       bit_ev, ws_s, sd_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= '0;
            ws_q  <= '0;
            sd_q  <= '0;
        end else begin
            sck_q <= {sck_q[1:0], i2s_sck};
            ws_q  <= {ws_q[0], i2s_ws};
            sd_q  <= {sd_q[0], i2s_sd};
        end
    end

    assign bit_ev = sck_q[1] & ~sck_q[2];
    assign ws_s   = ws_q[1];
    assign sd_s   = sd_q[1];

    state_e              state_q, state_d;
    logic                ws_prev_q, ws_prev_d;
    logic                ch_q, ch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic                frame_err_q, frame_err_d;
    logic                push_req, keep;
    logic [DATA_W-1:0]   push_data;

    assign keep      = (NUM_CH > 1) || !ch_q;
    assign push_data = {shift_q, sd_s};

    always_comb begin
        state_d     = state_q;
        ws_prev_d   = ws_prev_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                ws_prev_d = ws_s;
                cnt_d     = '0;
                if (en) state_d = StWaitWs;
            end
            StWaitWs: begin
                if (bit_ev) begin
                    ws_prev_d = ws_s;
                    if (ws_s != ws_prev_q) begin
                        state_d = StShift;
                        ch_d    = ws_s;
                        cnt_d   = '0;
                    end
                end
            end
            StShift: begin
                if (bit_ev) begin
                    ws_prev_d = ws_s;
                    // The bit on a ws edge is the old slot's last bit (one-bit delay)
                    if (cnt_q < CW'(DATA_W)) begin
                        shift_d  = (DATA_W-1)'({shift_q, sd_s});
                        cnt_d    = cnt_q + CW'(1);
                        push_req = keep && (cnt_q == CW'(DATA_W - 1));
                    end
                    if (ws_s != ws_prev_q) begin
                        frame_err_d = keep && (cnt_q < CW'(DATA_W - 1));
                        ch_d        = ws_s;
                        cnt_d       = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (!en) begin
            state_d     = StIdle;
            cnt_d       = '0;
            push_req    = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ws_prev_q   <= 1'b0;
            ch_q        <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ws_prev_q   <= ws_prev_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

    // Sample FIFO
    logic [DATA_W:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             pop, full, push_ok;
    logic [DATA_W:0]  head;

    assign out_valid = (level_q != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign push_ok   = push_req && (!full || pop);
    assign head      = mem[rd_q];

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LW'(1);
        end
        ovf_d = ovf_q;
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= {ch_q, push_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset, so gate the head word to keep outputs clean when empty
    assign out_ch     = out_valid ? head[DATA_W] : 1'b0;
    assign out_data   = out_valid ? head[DATA_W-1:0] : '0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

`ifdef I2S_RX_VAD_EN
    localparam int unsigned HW = $clog2(VAD_HANG + 1);

    logic [DATA_W-1:0] mag;
    logic [HW-1:0]     vad_cnt_q, vad_cnt_d;

    always_comb begin
        mag = push_data[DATA_W-1] ? (~push_data + DATA_W'(1)) : push_data;
        if (mag[DATA_W-1]) mag = {1'b0, {(DATA_W-1){1'b1}}};
        vad_cnt_d = vad_cnt_q;
        if (push_ok) begin
            if (mag >= DATA_W'(VAD_THRESH)) begin
                vad_cnt_d = HW'(VAD_HANG);
            end else if (vad_cnt_q != '0) begin
                vad_cnt_d = vad_cnt_q - HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vad_cnt_q <= '0;
        else        vad_cnt_q <= vad_cnt_d;
    end

    assign speech_valid = (vad_cnt_q != '0);
`else
    logic unused_vad_cfg;
    assign unused_vad_cfg = ^{32'(VAD_THRESH), 32'(VAD_HANG)};
    assign speech_valid   = out_valid;
`endif

endmodule

// File: tb/tb_i2s_rx_frame_buffer.sv
// Directed bench for i2s_rx_frame_buffer: drives I2S slots, scoreboards the output stream.
// Checks speech_valid against a sample-level activity model when I2S_RX_VAD_EN is defined.
`timescale 1ns/1ps
module tb_i2s_rx_frame_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int HANG  = 4;
`ifdef I2S_RX_VAD_EN
    localparam bit VAD_ON = 1'b1;
`else
    localparam bit VAD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          i2s_sck = 1'b0;
    logic          i2s_ws = 1'b1;
    logic          i2s_sd = 1'b0;
    logic          out_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_ch;
    logic          out_valid;
    logic [4:0]    fifo_level;
    logic          overflow;
    logic          frame_err;
    logic          speech_valid;

    int          vectors = 0;
    int          miscompares = 0;
    logic [16:0] exp_q[$];
    int          fe_count = 0;
    bit          vad_chk = 1'b0;
    int          vad_cnt = 0;
    bit          prev_bit = 1'b0;

    i2s_rx_frame_buffer #(
        .DATA_W    (DW),
        .NUM_CH    (2),
        .FIFO_DEPTH(DEPTH),
        .VAD_THRESH(512),
        .VAD_HANG  (HANG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .i2s_sck     (i2s_sck),
        .i2s_ws      (i2s_ws),
        .i2s_sd      (i2s_sd),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .frame_err   (frame_err),
        .speech_valid(speech_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    task automatic check_lat(input string name, input int lat);
        vectors++;
        if (lat < 1 || lat > 4) begin
            miscompares++;
            $display("FAIL %s: got %0d clk, want 1..4 clk", name, lat);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sck period; sd carries the previous bit (I2S one-bit delay relative to ws)
    task automatic sck_cycle(input bit ws, input bit b, output int lat);
        i2s_sck = 1'b0;
        i2s_ws  = ws;
        i2s_sd  = prev_bit;
        prev_bit = b;
        clks(4);
        i2s_sck = 1'b1;
        lat = -1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && out_valid) lat = k;
        end
    endtask

    task automatic send_slot(input bit ch, input logic [31:0] w, input int len, output int lat0);
        int lat;
        for (int i = 0; i < len; i++) begin
            sck_cycle(ch, (i < 32) ? w[31-i] : 1'b0, lat);
            if (i == 0) lat0 = lat;
        end
    endtask

    task automatic stop_sck();
        i2s_sck = 1'b0;
        clks(8);
    endtask

    task automatic restart();
        int lat;
        en = 1'b0;
        i2s_sck = 1'b0;
        i2s_ws = 1'b1;
        i2s_sd = 1'b0;
        prev_bit = 1'b0;
        clks(6);
        en = 1'b1;
        clks(2);
        sck_cycle(1'b1, 1'b0, lat);
        sck_cycle(1'b1, 1'b0, lat);
    endtask

    task automatic monitor();
        bit          prev_hold = 1'b0;
        logic [16:0] prev_word = '0;
        logic [16:0] w;
        int          s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (frame_err) fe_count++;
`ifndef I2S_RX_VAD_EN
                check("speech_valid tracks out_valid", speech_valid, out_valid);
`endif
                if (prev_hold) begin
                    check("stall keeps valid", out_valid, 1);
                    check("stall keeps word", {out_ch, out_data}, prev_word);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected sample: got 0x%0h, want none", {out_ch, out_data});
                    end else begin
                        w = exp_q.pop_front();
                        check("output sample {ch,data}", {out_ch, out_data}, w);
                        if (vad_chk) begin
                            s = $signed(w[15:0]);
                            if (s < 0) s = -s;
                            if (s > 32767) s = 32767;
                            if (s >= 512) vad_cnt = HANG;
                            else if (vad_cnt > 0) vad_cnt--;
                        end
                    end
                end
`ifdef I2S_RX_VAD_EN
                if (vad_chk) check("speech_valid vs model", speech_valid, vad_cnt != 0);
`endif
                prev_hold = out_valid && !out_ready;
                prev_word = {out_ch, out_data};
            end
        end
    endtask

    task automatic watchdog();
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    endtask

    initial begin
        int lat;
        int fe0;
        logic [15:0] w;
        fork
            monitor();
            watchdog();
        join_none

        // Reset values
        clks(3);
        check("reset outputs", {out_valid, out_ch, out_data, fifo_level, overflow, frame_err,
                                speech_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clks(2);

        // 1: one stereo frame, latency
        out_ready = 1'b1;
        restart();
        fe0 = fe_count;
        exp_q.push_back({1'b0, 16'h1234});
        exp_q.push_back({1'b1, 16'hFEDC});
        send_slot(1'b0, 32'h1234_0000, 16, lat);
        send_slot(1'b1, 32'hFEDC_0000, 16, lat);
        check_lat("latency left", lat);
        sck_cycle(1'b0, 1'b0, lat);
        check_lat("latency right", lat);
        stop_sck();
        check("t1 all samples out", exp_q.size(), 0);
        check("t1 level", fifo_level, 0);
        check("t1 frame_err count", fe_count - fe0, 0);

        // 2: 32-bit slots, low half ignored
        restart();
        fe0 = fe_count;
        exp_q.push_back({1'b0, 16'hA5C3});
        exp_q.push_back({1'b1, 16'h5A3C});
        send_slot(1'b0, 32'hA5C3_0F0F, 32, lat);
        send_slot(1'b1, 32'h5A3C_F0F0, 32, lat);
        sck_cycle(1'b0, 1'b0, lat);
        stop_sck();
        check("t2 all samples out", exp_q.size(), 0);
        check("t2 frame_err count", fe_count - fe0, 0);

        // 3: overflow with consumer stalled
        out_ready = 1'b0;
        restart();
        fe0 = fe_count;
        for (int i = 0; i < DEPTH + 2; i++) begin
            w = 16'(16'h8001 + i * 16'h0707);
            if (i < DEPTH) exp_q.push_back({1'(i % 2), w});
            send_slot(1'(i % 2), {w, 16'h0000}, 16, lat);
        end
        sck_cycle(1'b0, 1'b0, lat);
        stop_sck();
        check("t3 level full", fifo_level, DEPTH);
        check("t3 overflow set", overflow, 1);
        out_ready = 1'b1;
        clks(DEPTH + 4);
        check("t3 drained", exp_q.size(), 0);
        check("t3 level empty", fifo_level, 0);
        check("t3 overflow sticky", overflow, 1);
        ovf_clr = 1'b1;
        clks(1);
        ovf_clr = 1'b0;
        clks(1);
        check("t3 overflow cleared", overflow, 0);
        check("t3 frame_err count", fe_count - fe0, 0);

        // 4: short slot
        restart();
        fe0 = fe_count;
        exp_q.push_back({1'b1, 16'h1357});
        send_slot(1'b0, 32'hABCD_0000, 8, lat);
        send_slot(1'b1, 32'h1357_0000, 16, lat);
        sck_cycle(1'b0, 1'b0, lat);
        stop_sck();
        check("t4 frame_err count", fe_count - fe0, 1);
        check("t4 only full slot out", exp_q.size(), 0);

        // 6: en drop mid-slot, then reset with entries queued
        out_ready = 1'b0;
        restart();
        fe0 = fe_count;
        send_slot(1'b0, 32'h1111_0000, 16, lat);
        send_slot(1'b1, 32'h2222_0000, 16, lat);
        send_slot(1'b0, 32'h3333_0000, 16, lat);
        send_slot(1'b1, 32'h4444_0000, 8, lat);
        i2s_sck = 1'b0;
        en = 1'b0;
        clks(6);
        check("t6 level after en drop", fifo_level, 3);
        en = 1'b1;
        clks(2);
        for (int i = 0; i < 8; i++) sck_cycle(1'b1, 1'b0, lat);
        sck_cycle(1'b0, 1'b0, lat);
        stop_sck();
        check("t6 partial discarded", fifo_level, 3);
        check("t6 frame_err count", fe_count - fe0, 0);
        rst_n = 1'b0;
        exp_q.delete();
        clks(2);
        check("t6 outputs in reset", {out_valid, out_ch, out_data, fifo_level, overflow,
                                      frame_err, speech_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clks(2);
        check("t6 level after reset", fifo_level, 0);
        check("t6 valid after reset", out_valid, 0);

        // 5: activity flag hang time
        out_ready = 1'b1;
        restart();
        vad_cnt = 0;
        vad_chk = 1'b1;
        exp_q.push_back({1'b0, 16'h8000});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b0, 16'h0000});
        send_slot(1'b0, 32'h8000_0000, 16, lat);
        send_slot(1'b1, 32'h0000_0000, 16, lat);
        check("t5 active after 8000", speech_valid, VAD_ON);
        send_slot(1'b0, 32'h0000_0000, 16, lat);
        send_slot(1'b1, 32'h0000_0000, 16, lat);
        sck_cycle(1'b0, 1'b0, lat);
        i2s_sck = 1'b0;
        clks(6);
        check("t5 active after 3 zeros", speech_valid, VAD_ON);
        for (int i = 1; i < 16; i++) sck_cycle(1'b0, 1'b0, lat);
        sck_cycle(1'b1, 1'b0, lat);
        stop_sck();
        check("t5 idle after 4 zeros", speech_valid, 0);
        check("t5 all samples out", exp_q.size(), 0);
        vad_chk = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
